// File: rtl/sparam_sweep_sequencer.sv
// Two-port S-parameter sweep sequencer: bias, settle, step frequency, excite port 1/2, average reads.
// Optional DC_BIAS_CHECK_EN adds bias_mon plus a one-cycle bias window check after the bias settle.
module sparam_sweep_sequencer #(
  parameter int unsigned FW          = 32,
  parameter int unsigned PW          = 10,
  parameter int unsigned DW          = 16,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
`ifdef DC_BIAS_CHECK_EN
  ,
  parameter int          BIAS_MIN    = 0,
  parameter int          BIAS_MAX    = 1000
`endif
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [PW-1:0] n_points,
  output logic          bias_en,
  output logic [1:0]    src_port,
  output logic [FW-1:0] freq_word,
  output logic          meas_req,
  input  logic          meas_ack,
  input  logic [DW-1:0] meas_data,
`ifdef DC_BIAS_CHECK_EN
  input  logic [DW-1:0] bias_mon,
`endif
  output logic          res_valid,
  output logic [PW-1:0] res_point,
  output logic [1:0]    res_sel,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned AW   = DW + AVG_LOG2;
  localparam int unsigned NC   = AVG_LOG2 + 1;
  localparam int unsigned CMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SettleLast  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT_CYC - 1);
  localparam logic [NC-1:0] AvgLast     = NC'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    StIdle, StSettle, StReq, StWait, StEmit, StNext, StDone
`ifdef DC_BIAS_CHECK_EN
    , StBchk
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NC-1:0]        avg_q, avg_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [FW-1:0]        freq_q, freq_d, step_q, step_d;
  logic [PW-1:0]        npts_q, npts_d, point_q, point_d;
  logic                 port_q, port_d, sub_q, sub_d, err_q, err_d;
  logic                 last_point, active;

  assign last_point = (point_q == npts_q - PW'(1));

`ifdef DC_BIAS_CHECK_EN
  logic bias_ok;
  assign bias_ok = (int'($signed(bias_mon)) >= BIAS_MIN) && (int'($signed(bias_mon)) <= BIAS_MAX);
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start && !abort) state_d = (n_points == '0) ? StDone : StSettle;
`ifdef DC_BIAS_CHECK_EN
        // Only the first settle of a sweep (point 0, port 1) follows bias-on.
        StSettle: if (cnt_q == SettleLast)
                    state_d = (point_q == '0 && !port_q) ? StBchk : StReq;
        StBchk:   state_d = bias_ok ? StReq : StIdle;
`else
        StSettle: if (cnt_q == SettleLast) state_d = StReq;
`endif
        StReq:    state_d = StWait;
        StWait:   if (meas_ack)                   state_d = (avg_q == AvgLast) ? StEmit : StReq;
                  else if (cnt_q == TimeoutLast)  state_d = StIdle;
        StEmit:   if (!sub_q)          state_d = StReq;
                  else if (!port_q)    state_d = StSettle;
                  else if (last_point) state_d = StDone;
                  else                 state_d = StNext;
        StNext:   state_d = StSettle;
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = (state_q == StIdle || state_d != state_q) ? '0 : cnt_q + CW'(1);
    avg_d   = avg_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    step_d  = step_q;
    npts_d  = npts_q;
    point_d = point_q;
    port_d  = port_q;
    sub_d   = sub_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        avg_d = '0;
        if (start && !abort) begin
          freq_d  = f_start;
          step_d  = f_step;
          npts_d  = n_points;
          point_d = '0;
          port_d  = 1'b0;
          sub_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      StWait: begin
        if (meas_ack) begin
          acc_d = acc_q + AW'($signed(meas_data));
          avg_d = (avg_q == AvgLast) ? '0 : avg_q + NC'(1);
        end else if (cnt_q == TimeoutLast && !abort) begin
          err_d = 1'b1;
        end
      end
      StEmit: begin
        acc_d = '0;
        sub_d = !sub_q;
        if (sub_q) port_d = !port_q;
      end
      StNext: begin
        point_d = point_q + PW'(1);
        freq_d  = freq_q + step_q;
      end
`ifdef DC_BIAS_CHECK_EN
      StBchk: if (!bias_ok && !abort) err_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q   <= '0;
      avg_q   <= '0;
      acc_q   <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      npts_q  <= '0;
      point_q <= '0;
      port_q  <= 1'b0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      step_q  <= step_d;
      npts_q  <= npts_d;
      point_q <= point_d;
      port_q  <= port_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    active    = (state_q != StIdle) && (state_q != StDone);
    bias_en   = active;
    busy      = active;
    src_port  = active ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    freq_word = active ? freq_q : '0;
    meas_req  = (state_q == StWait);
    res_valid = (state_q == StEmit);
    res_point = res_valid ? point_q : '0;
    res_sel   = res_valid ? {port_q, sub_q} : 2'b00;
    res_data  = res_valid ? DW'(acc_q >>> AVG_LOG2) : '0;
    done      = (state_q == StDone);
    err       = err_q;
  end

endmodule

// File: tb/tb_sparam_sweep_sequencer.sv
// Self-checking bench for sparam_sweep_sequencer: table-driven sweeps plus timeout, abort,
// mid-sweep reset and (with DC_BIAS_CHECK_EN) bias window cases.
module tb_sparam_sweep_sequencer;
  localparam int unsigned FW = 32, PW = 10, DW = 16, AL = 2, SC = 4, TC = 16;

  logic          clk = 1'b0, nreset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [FW-1:0] f_start = '0, f_step = '0;
  logic [PW-1:0] n_points = '0;
  logic          bias_en, meas_req, res_valid, busy, done, err;
  logic [1:0]    src_port, res_sel;
  logic [FW-1:0] freq_word;
  logic [PW-1:0] res_point;
  logic [DW-1:0] res_data;
  logic          meas_ack = 1'b0;
  logic [DW-1:0] meas_data = '0;
`ifdef DC_BIAS_CHECK_EN
  logic [DW-1:0] bias_mon = 16'd150;
`endif

  int errors = 0, checks = 0;
  logic resp_en = 1'b1;
  logic [DW-1:0] rd [4];
  int ack_idx = 0;

  sparam_sweep_sequencer #(
    .FW(FW), .PW(PW), .DW(DW), .AVG_LOG2(AL), .SETTLE_CYC(SC), .TIMEOUT_CYC(TC)
`ifdef DC_BIAS_CHECK_EN
    , .BIAS_MIN(100), .BIAS_MAX(200)
`endif
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points),
    .bias_en(bias_en), .src_port(src_port), .freq_word(freq_word),
    .meas_req(meas_req), .meas_ack(meas_ack), .meas_data(meas_data),
`ifdef DC_BIAS_CHECK_EN
    .bias_mon(bias_mon),
`endif
    .res_valid(res_valid), .res_point(res_point), .res_sel(res_sel), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Measurement engine: acks one cycle after it sees a request, cycling through rd[].
  always @(negedge clk) begin
    if (resp_en && meas_req && !meas_ack) begin
      meas_ack  = 1'b1;
      meas_data = rd[ack_idx % 4];
      ack_idx   = ack_idx + 1;
    end else begin
      meas_ack = 1'b0;
    end
    if (!busy) ack_idx = 0;
  end

  typedef struct {
    logic [FW-1:0] fs;
    logic [FW-1:0] st;
    logic [PW-1:0] np;
    logic [DW-1:0] r0, r1, r2, r3;
    logic [DW-1:0] exp_res;
    logic [FW-1:0] exp_f_last;
    bit            restart;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int idx, input vec_t v);
    int res_cnt = 0, done_cnt = 0, done_cyc = 0, bias_seen = 0;
    logic [FW-1:0] last_f = '0;
    logic [FW-1:0] mf;
    rd[0] = v.r0; rd[1] = v.r1; rd[2] = v.r2; rd[3] = v.r3;
    f_start = v.fs; f_step = v.st; n_points = v.np; start = 1'b1;
    for (int c = 1; c <= 300 * (int'(v.np) + 1); c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk($sformatf("v%0d err_cleared", idx), 64'(err), 64'(0));
      end
      if (v.restart && c == 30) begin start = 1'b1; n_points = 10'd5; end
      if (v.restart && c == 31) start = 1'b0;
      if (bias_en) bias_seen++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (res_valid) begin
        mf = v.fs + FW'(res_cnt / 4) * v.st;
        chk($sformatf("v%0d r%0d sel", idx, res_cnt), 64'(res_sel), 64'(res_cnt % 4));
        chk($sformatf("v%0d r%0d point", idx, res_cnt), 64'(res_point), 64'(res_cnt / 4));
        chk($sformatf("v%0d r%0d data", idx, res_cnt), 64'(res_data), 64'(v.exp_res));
        chk($sformatf("v%0d r%0d freq", idx, res_cnt), 64'(freq_word), 64'(mf));
        last_f = freq_word;
        res_cnt++;
      end
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
    chk($sformatf("v%0d res_count", idx), 64'(res_cnt), 64'(4 * int'(v.np)));
    chk($sformatf("v%0d done_count", idx), 64'(done_cnt), 64'(1));
    chk($sformatf("v%0d bias_seen", idx), 64'(bias_seen > 0), 64'(v.np != 0));
    chk($sformatf("v%0d err_end", idx), 64'(err), 64'(0));
    if (v.np == 0) chk($sformatf("v%0d done_latency", idx), 64'(done_cyc), 64'(1));
    else           chk($sformatf("v%0d freq_last", idx), 64'(last_f), 64'(v.exp_f_last));
  endtask

  initial begin
    int req_cyc, dn, rv, extra, abort_c, reqs1, res_cnt;
    bit aborted;
    vecs[0] = '{32'd100, 32'd50, 10'd2, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 32'd150, 1'b1};
    vecs[1] = '{32'd0, 32'd1, 10'd1, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 32'd0,
                1'b0};
    vecs[2] = '{32'hFFFF_FFF0, 32'h20, 10'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 32'h10, 1'b0};
    vecs[3] = '{32'd5, 32'd7, 10'd3, 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF7, 16'hFFF7, 32'd19,
                1'b0};
    vecs[4] = '{32'h1234, 32'd0, 10'd1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                32'h1234, 1'b0};
    vecs[5] = '{32'd0, 32'd0, 10'd1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'd0,
                1'b0};
    vecs[6] = '{32'd10, 32'd10, 10'd1, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 32'd10, 1'b0};
    vecs[7] = '{32'd77, 32'd1, 10'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 32'd0, 1'b0};

    #2 nreset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", 64'({bias_en, src_port, meas_req, res_valid, busy, done, err}), 64'(0));
    chk("reset data", 64'({freq_word, res_point, res_sel}), 64'(0));
    chk("reset res_data", 64'(res_data), 64'(0));
    nreset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_sweep(i, vecs[i]);

    // No ack: timeout after exactly TC request cycles.
    resp_en = 1'b0; req_cyc = 0; dn = 0;
    f_start = 32'd3; f_step = 32'd0; n_points = 10'd1; start = 1'b1;
    for (int c = 1; c <= int'(SC + TC) + 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (meas_req) req_cyc++;
      if (done) dn++;
      if (err) break;
    end
    chk("timeout err", 64'(err), 64'(1));
    chk("timeout req_cycles", 64'(req_cyc), 64'(TC));
    chk("timeout outs", 64'({busy, bias_en, src_port, meas_req, freq_word}), 64'(0));
    chk("timeout no_done", 64'(dn), 64'(0));
    resp_en = 1'b1;
    run_sweep(8, vecs[4]);

    // Abort on the 4th ack of S11 at point 1.
    rd[0] = 16'd8; rd[1] = 16'd8; rd[2] = 16'd8; rd[3] = 16'd8;
    f_start = 32'd100; f_step = 32'd50; n_points = 10'd2; start = 1'b1;
    aborted = 1'b0; abort_c = 0; extra = 0; reqs1 = 0; res_cnt = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (aborted) begin
        if (c == abort_c + 1) begin
          abort = 1'b0;
          chk("abort ctrl", 64'({bias_en, src_port, meas_req, res_valid, busy, done}), 64'(0));
          chk("abort data", 64'({freq_word, res_point, res_sel, res_data}), 64'(0));
        end
        if (res_valid || done) extra++;
        if (c >= abort_c + 10) break;
      end else begin
        if (res_valid) res_cnt++;
        if (res_cnt == 4 && meas_req) begin
          reqs1++;
          if (reqs1 == 4) begin abort = 1'b1; aborted = 1'b1; abort_c = c; end
        end
      end
    end
    abort = 1'b0;
    chk("abort reached", 64'(aborted), 64'(1));
    chk("abort no_result", 64'(extra), 64'(0));
    chk("abort err", 64'(err), 64'(0));

    // Asynchronous reset in the middle of an averaging run.
    rd[0] = 16'd100; rd[1] = 16'd100; rd[2] = 16'd100; rd[3] = 16'd100;
    f_start = 32'd9; f_step = 32'd1; n_points = 10'd1; start = 1'b1; req_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (meas_req) req_cyc++;
      if (req_cyc == 2) break;
    end
    chk("mid reset reached", 64'(req_cyc), 64'(2));
    nreset = 1'b0;
    #1;
    chk("mid reset outs", 64'({bias_en, src_port, meas_req, busy, done, err, freq_word}), 64'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    run_sweep(9, vecs[1]);

`ifdef DC_BIAS_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      bias_mon = (k == 0) ? 16'd50 : 16'd250;
      f_start = 32'd1; f_step = 32'd1; n_points = 10'd1; start = 1'b1; rv = 0;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (res_valid) rv++;
        if (err) break;
      end
      chk($sformatf("bias%0d err", k), 64'(err), 64'(1));
      chk($sformatf("bias%0d outs", k), 64'({bias_en, busy, meas_req, src_port}), 64'(0));
      chk($sformatf("bias%0d no_res", k), 64'(rv), 64'(0));
    end
    bias_mon = 16'd150;
    run_sweep(10, vecs[6]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
